// File: rtl/dpwm_pkg.sv
// Shared widths, limits and state encoding for the DPWM comparator stage.
package dpwm_pkg;

    localparam int CNT_W      = 10;
    localparam int DUTY_MAX   = 1000;
    localparam int RESET_DUTY = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

endpackage

// File: rtl/dpwm_duty_buffer.sv
// Double-buffered duty register: clamped shadow loaded through valid/ready,
// copied into the active register only at a period boundary.
module dpwm_duty_buffer
    import dpwm_pkg::*;
#(
    parameter int CNT_W      = dpwm_pkg::CNT_W,
    parameter int DUTY_MAX   = dpwm_pkg::DUTY_MAX,
    parameter int RESET_DUTY = dpwm_pkg::RESET_DUTY
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wrap,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [CNT_W-1:0] duty_active,
    output logic [CNT_W-1:0] duty_next
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0] RST_V = CNT_W'(RESET_DUTY);

    logic [CNT_W-1:0] shadow;
    logic             pending;
    logic             take;
    logic             load;

    // ready comes straight from the pending flop, never from duty_valid
    assign duty_ready = !pending;
    assign take       = duty_valid && !pending;
    assign load       = wrap && pending;
    assign duty_next  = load ? shadow : duty_active;

    always_ff @(posedge CLK) begin
        if (reset) begin
            shadow      <= RST_V;
            pending     <= 1'b0;
            duty_active <= RST_V;
        end else begin
            if (take) begin
                shadow  <= (duty_in > MAX_V) ? MAX_V : duty_in;
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            duty_active <= duty_next;
        end
    end

endmodule

// File: rtl/dpwm_comparador.sv
// DPWM output stage: period-wrap detection, sync state machine and the
// count-versus-duty comparator driving a registered PWM output.
//
// state     | meaning
// IDLE      | disabled, output held low
// WAIT_SYNC | enabled, waiting for the next count wrap
// RUN       | output follows count < active duty
module dpwm_comparador
    import dpwm_pkg::*;
#(
    parameter int CNT_W      = dpwm_pkg::CNT_W,
    parameter int DUTY_MAX   = dpwm_pkg::DUTY_MAX,
    parameter int RESET_DUTY = dpwm_pkg::RESET_DUTY
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] cuenta,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_active,
    output logic             sync_ok
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cuenta_q;
    logic [CNT_W-1:0] duty_next;
    logic             wrap;
    logic             pwm_d;

    assign wrap    = cuenta < cuenta_q;
    assign sync_ok = (state == RUN);

    dpwm_duty_buffer #(
        .CNT_W      (CNT_W),
        .DUTY_MAX   (DUTY_MAX),
        .RESET_DUTY (RESET_DUTY)
    ) u_buf (
        .CLK         (CLK),
        .reset       (reset),
        .wrap        (wrap),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .duty_active (duty_active),
        .duty_next   (duty_next)
    );

    // Output is computed for the state being entered, so the sample that
    // moves WAIT_SYNC into RUN (count 0) already produces a full period.
    always_comb begin
        state_nxt = state;
        pwm_d     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_SYNC;
                WAIT_SYNC: if (wrap) state_nxt = RUN;
                RUN:       state_nxt = RUN;
                default:   state_nxt = IDLE;
            endcase
        end
        if (state_nxt == RUN)
            pwm_d = cuenta < duty_next;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IDLE;
            cuenta_q     <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            cuenta_q     <= cuenta;
            pwm_out      <= pwm_d;
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_dpwm_comparador.sv
// Scoreboard bench for dpwm_comparador: directed count sequences push the
// expected outputs; a negedge monitor pops and compares them.
module tb_dpwm_comparador;

    logic       CLK = 1'b0;
    logic       reset;
    logic       enable;
    logic       duty_valid;
    logic [9:0] cuenta;
    logic [9:0] duty_in;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic [9:0] duty_active;
    logic       sync_ok;

    typedef struct {
        int         cyc;
        int         tag;
        logic       p;
        logic       ps;
        logic       s;
        logic       r;
        logic [9:0] a;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    always #5 CLK = ~CLK;

    dpwm_comparador dut (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (enable),
        .cuenta       (cuenta),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active),
        .sync_ok      (sync_ok)
    );

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int t, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s tag=%0d cyc=%0d got=%0d exp=%0d", name, t, cyc, got, want);
        end
    endtask

    always @(negedge CLK) begin
        exp_t it;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            it = sb.pop_front();
            total++;
            bad++;
            $display("FAIL stale_entry tag=%0d cyc=%0d got=none exp=cyc%0d", it.tag, cyc, it.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            it = sb.pop_front();
            chk("pwm_out",      it.tag, {9'd0, pwm_out},      {9'd0, it.p});
            chk("period_start", it.tag, {9'd0, period_start}, {9'd0, it.ps});
            chk("sync_ok",      it.tag, {9'd0, sync_ok},      {9'd0, it.s});
            chk("duty_ready",   it.tag, {9'd0, duty_ready},   {9'd0, it.r});
            chk("duty_active",  it.tag, duty_active,          it.a);
        end
    end

    // Drive one sample and queue the outputs expected after the next edge.
    task automatic step(input logic [9:0] c, input logic e, input logic v, input logic [9:0] d,
                        input logic xp, input logic xps, input logic xs, input logic xr,
                        input logic [9:0] xa);
        exp_t it;
        cuenta     = c;
        enable     = e;
        duty_valid = v;
        duty_in    = d;
        it.cyc = cyc + 1;
        it.tag = tag;
        it.p   = xp;
        it.ps  = xps;
        it.s   = xs;
        it.r   = xr;
        it.a   = xa;
        sb.push_back(it);
        @(posedge CLK);
        #1;
    endtask

    // One enabled period 0..1000; act is the duty in force after the wrap,
    // ready reads low from sample index drop onwards.
    task automatic period(input logic [9:0] act, input logic run, input int wf, input int wt,
                          input logic [9:0] v1, input logic [9:0] v2, input int drop);
        logic [9:0] c;
        for (int k = 0; k < 21; k++) begin
            c = 10'(k * 50);
            step(c, 1'b1, (k >= wf && k <= wt), (k == wf) ? v1 : v2,
                 run && (c < act), (k == 0), run, (k < drop), act);
        end
    endtask

    initial begin
        logic [9:0] c;
        reset = 1'b1; enable = 1'b1; duty_valid = 1'b0; cuenta = 10'd951; duty_in = 10'd0;

        tag = 1;
        step(10'd951, 1, 0, 0, 0, 0, 0, 1, 0);
        step(10'd951, 1, 0, 0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        step(10'd951,  1, 0, 0, 0, 0, 0, 1, 0);
        step(10'd1001, 1, 0, 0, 0, 0, 0, 1, 0);
        period(10'd0, 1, -1, -1, 10'd0, 10'd0, 21);

        tag = 2; period(10'd0,    1, 1, 1, 10'd500,  10'd500,  1);
        tag = 3; period(10'd500,  1, 1, 1, 10'd1023, 10'd1023, 1);
        tag = 4; period(10'd1000, 1, 1, 1, 10'd0,    10'd0,    1);
        tag = 5; period(10'd0,    1, 1, 1, 10'd50,   10'd50,   1);
        tag = 6; period(10'd50,   1, 1, 20, 10'd300, 10'd700,  1);
        tag = 7; period(10'd300,  1, 0, 1, 10'd700,  10'd700,  1);
        tag = 8; period(10'd700,  1, -1, -1, 10'd0,  10'd0,    21);

        tag = 9;
        for (int k = 0; k < 21; k++) begin
            c = 10'(k * 50);
            if (k < 4) step(c, 1, 0, 0, (c < 10'd700), (k == 0), 1, 1, 10'd700);
            else       step(c, 0, 0, 0, 0, 0, 0, 1, 10'd700);
        end
        for (int k = 0; k < 21; k++) begin
            c = 10'(k * 50);
            step(c, (k >= 4), 0, 0, 0, (k == 0), 0, 1, 10'd700);
        end
        tag = 10; period(10'd700, 1, -1, -1, 10'd0, 10'd0, 21);

        tag = 11;
        step(10'd0,  1, 0, 0,       1, 1, 1, 1, 10'd700);
        step(10'd50, 1, 1, 10'd200, 1, 0, 1, 0, 10'd700);
        for (int k = 2; k < 5; k++) step(10'(k * 50), 1, 0, 0, 1, 0, 1, 0, 10'd700);
        reset = 1'b1;
        step(10'd250, 1, 0, 0, 0, 0, 0, 1, 10'd0);
        reset = 1'b0;
        for (int k = 6; k < 21; k++) step(10'(k * 50), 1, 0, 0, 0, 0, 0, 1, 10'd0);
        tag = 12; period(10'd0, 1, -1, -1, 10'd0, 10'd0, 21);

        duty_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
